// File: rtl/vga_pattern_pkg.sv
// Shared types for the VGA test-pattern path: display-mode codes and debounce FSM encoding.
package vga_pattern_pkg;

  localparam int NUM_MODES = 14;

  typedef enum logic [3:0] {
    BLACK     = 4'd0,
    WHITE     = 4'd1,
    RED       = 4'd2,
    GREEN     = 4'd3,
    BLUE      = 4'd4,
    GRID_S    = 4'd5,
    GRID_L    = 4'd6,
    HGRAD     = 4'd7,
    VGRAD     = 4'd8,
    HGRAD_R   = 4'd9,
    HGRAD_G   = 4'd10,
    HGRAD_B   = 4'd11,
    BARS      = 4'd12,
    ALT_WHITE = 4'd13
  } mode_t;

  localparam mode_t LAST_MODE = mode_t'(4'(NUM_MODES - 1));

  typedef logic [1:0] deb_state_t;

  localparam deb_state_t DEB_IDLE      = 2'd0;
  localparam deb_state_t DEB_PRESS_CNT = 2'd1;
  localparam deb_state_t DEB_HELD      = 2'd2;
  localparam deb_state_t DEB_REL_CNT   = 2'd3;

  // Modes cycle through 0..NUM_MODES-1 and wrap back to BLACK.
  function automatic mode_t next_mode(input mode_t m);
    return (m == LAST_MODE) ? BLACK : mode_t'(m + 4'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus press/release debounce; emits one key_req per qualified press.
module key_debounce
  import vga_pattern_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 90000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic key_req
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          key_s_q;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_req = 1'b0;
    case (state_q)
      DEB_IDLE: begin
        if (!key_s_q) begin
          state_d = DEB_PRESS_CNT;
          cnt_d   = '0;
        end
      end
      DEB_PRESS_CNT: begin
        if (key_s_q) begin
          state_d = DEB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DEB_HELD;
          key_req = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Holding the key never re-arms; only a qualified release returns to IDLE.
      DEB_HELD: begin
        if (key_s_q) begin
          state_d = DEB_REL_CNT;
          cnt_d   = '0;
        end
      end
      DEB_REL_CNT: begin
        if (!key_s_q) begin
          state_d = DEB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DEB_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = DEB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
      state_q <= DEB_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      key_s_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_mode_ctrl.sv
// Display-mode controller: merges key and auto-advance requests, commits one step per frame boundary.
module pattern_mode_ctrl
  import vga_pattern_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 90000,
  parameter int unsigned AUTO_CYCLES     = 120000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_n,
  input  logic       auto_en,
  input  logic       frame_start,
  output logic [3:0] mode,
  output logic       mode_change,
  output logic       led
);

  localparam int unsigned AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

  logic          key_req;
  logic          auto_req;
  logic          req;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          pending_q, pending_d;
  logic          mode_change_q, mode_change_d;
  logic          led_q, led_d;
  mode_t         mode_q, mode_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk     (clk),
    .rstn    (rstn),
    .key_n   (key_n),
    .key_req (key_req)
  );

  // A manual press restarts the auto interval so the two don't fire back to back.
  always_comb begin
    auto_req = auto_en && (auto_cnt_q == AUTO_LAST);
    if (!auto_en || key_req || auto_req) begin
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + AW'(1);
    end
  end

  assign req = key_req | auto_req;

  // Requests collapse into pending; a request landing on frame_start is applied right there.
  always_comb begin
    mode_d        = mode_q;
    led_d         = led_q;
    mode_change_d = 1'b0;
    pending_d     = pending_q | req;
    if (frame_start && (pending_q || req)) begin
      mode_d        = next_mode(mode_q);
      led_d         = ~led_q;
      mode_change_d = 1'b1;
      pending_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      auto_cnt_q    <= '0;
      pending_q     <= 1'b0;
      mode_change_q <= 1'b0;
      led_q         <= 1'b0;
      mode_q        <= BLACK;
    end else begin
      auto_cnt_q    <= auto_cnt_d;
      pending_q     <= pending_d;
      mode_change_q <= mode_change_d;
      led_q         <= led_d;
      mode_q        <= mode_d;
    end
  end

  assign mode        = mode_q;
  assign mode_change = mode_change_q;
  assign led         = led_q;

endmodule

// File: tb/tb_pattern_mode_ctrl.sv
// Bench for pattern_mode_ctrl: directed scenarios plus random key/auto traffic against a run-length reference model.
module tb_pattern_mode_ctrl;

  localparam int DEB   = 4;
  localparam int AUTO  = 20;
  localparam int FRAME = 50;
  localparam int NM    = 14;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] mode;
  logic       mode_change;
  logic       led;

  pattern_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_CYCLES    (AUTO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_n       (key_n),
    .auto_en     (auto_en),
    .frame_start (frame_start),
    .mode        (mode),
    .mode_change (mode_change),
    .led         (led)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         mc_seen = 0;
  logic [3:0] exp_q[$];
  logic [3:0] chg_log[$];

  // reference model: press/release judged by run lengths of the synchronized key
  int   m_mode, m_led, m_mc, m_pending;
  int   m_released, m_run, m_elapsed;
  logic key_line[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d required %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_led = 0; m_mc = 0; m_pending = 0;
    m_released = 1; m_run = 0; m_elapsed = 0;
    key_line.delete();
    key_line.push_back(1'b1);
    key_line.push_back(1'b1);
    exp_q.delete();
  endtask

  task automatic model_cycle();
    logic ks;
    int   key_req, auto_req, req;
    ks = key_line.pop_front();
    key_line.push_back(key_n);
    key_req = 0;
    if (m_released != 0) begin
      m_run = (ks == 1'b0) ? m_run + 1 : 0;
      if (m_run == DEB + 1) begin
        key_req = 1; m_released = 0; m_run = 0;
      end
    end else begin
      m_run = (ks == 1'b1) ? m_run + 1 : 0;
      if (m_run == DEB + 1) begin
        m_released = 1; m_run = 0;
      end
    end
    auto_req = (auto_en && m_elapsed == AUTO - 1) ? 1 : 0;
    if (!auto_en || key_req != 0 || auto_req != 0) m_elapsed = 0;
    else m_elapsed++;
    req = key_req | auto_req;
    if (frame_start && (m_pending != 0 || req != 0)) begin
      m_mode = (m_mode + 1) % NM;
      m_led = 1 - m_led;
      m_mc = 1;
      m_pending = 0;
      exp_q.push_back(4'(m_mode));
    end else begin
      m_mc = 0;
      if (req != 0) m_pending = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    frame_start = (cyc % FRAME == 0);
    if (!rstn) model_reset();
    else model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    check("mode", mode, m_mode);
    check("mode_change", mode_change, m_mc);
    check("led", led, m_led);
    check("mode_range", (mode < 4'(NM)), 1);
    if (mode_change === 1'b1) begin
      mc_seen++;
      chg_log.push_back(mode);
      check("commit_queue", exp_q.size(), 1);
      if (exp_q.size() > 0) check("commit_mode", mode, exp_q.pop_front());
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic to_phase(input int p);
    while (cyc % FRAME != p) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int mc0;
    logic [3:0] old_mode;
    int key_hold;

    model_reset();
    rstn = 1'b0;
    run(3);
    check("reset_mode", mode, 0);
    check("reset_led", led, 0);
    check("reset_mode_change", mode_change, 0);
    rstn = 1'b1;

    // idle: three frames, nothing happens
    mc0 = mc_seen;
    run(3 * FRAME);
    check("idle_changes", mc_seen - mc0, 0);
    check("idle_mode", mode, 0);
    check("idle_led", led, 0);

    // clean press: 10 low then release
    to_phase(5);
    mc0 = mc_seen;
    key_n = 1'b0;
    run(10);
    key_n = 1'b1;
    to_phase(10);
    check("press_changes", mc_seen - mc0, 1);
    check("press_mode", mode, 1);
    check("press_led", led, 1);

    // glitches: 2-cycle low, then toggling each cycle
    mc0 = mc_seen;
    key_n = 1'b0;
    run(2);
    for (int i = 0; i < 30; i++) begin
      key_n = ~key_n;
      step();
    end
    key_n = 1'b1;
    run(2 * FRAME);
    check("glitch_changes", mc_seen - mc0, 0);
    check("glitch_mode", mode, 1);

    // auto-advance up to 12, then watch the wrap
    auto_en = 1'b1;
    for (int i = 0; i < 2000 && mode != 4'd12; i++) step();
    check("reach_mode12", mode, 12);
    chg_log.delete();
    run(4 * FRAME);
    check("auto_changes", chg_log.size(), 4);
    if (chg_log.size() == 4) begin
      check("auto_seq0", chg_log[0], 13);
      check("auto_seq1", chg_log[1], 0);
      check("auto_seq2", chg_log[2], 1);
      check("auto_seq3", chg_log[3], 2);
    end
    auto_en = 1'b0;
    run(FRAME + 5);

    // key_req lands exactly on frame_start
    to_phase(44);
    old_mode = mode;
    mc0 = mc_seen;
    key_n = 1'b0;
    run(7);
    check("coincident_change", mode_change, 1);
    check("coincident_mode", mode, 4'((old_mode + 1) % NM));
    run(3);
    key_n = 1'b1;
    run(FRAME);
    check("coincident_count", mc_seen - mc0, 1);

    // pending request discarded by reset mid-frame
    to_phase(5);
    key_n = 1'b0;
    run(8);
    key_n = 1'b1;
    to_phase(25);
    mc0 = mc_seen;
    rstn = 1'b0;
    run(3);
    rstn = 1'b1;
    check("rst_mode", mode, 0);
    check("rst_led", led, 0);
    run(FRAME + 10);
    check("rst_no_advance", mc_seen - mc0, 0);
    check("rst_mode_after", mode, 0);

    // random key / auto / reset traffic
    key_hold = 1;
    for (int i = 0; i < 2500; i++) begin
      key_hold--;
      if (key_hold <= 0) begin
        key_n = ~key_n;
        key_hold = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 999) == 0) rstn = 1'b0;
      else rstn = 1'b1;
      step();
    end
    rstn = 1'b1;
    key_n = 1'b1;
    auto_en = 1'b0;
    run(2 * FRAME);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
